// File: rtl/mips_dbus_responder_pkg.sv
// Shared definitions for the MIPS data-bus responder: MMIO word offsets,
// STATUS bit positions and the decode region type.
package mips_dbus_responder_pkg;

    localparam logic [1:0] OFF_COUNTER = 2'd0;
    localparam logic [1:0] OFF_COMPARE = 2'd1;
    localparam logic [1:0] OFF_STATUS  = 2'd2;
    localparam logic [1:0] OFF_TXDATA  = 2'd3;

    localparam int ST_MATCH     = 0;
    localparam int ST_FULL      = 1;
    localparam int ST_EMPTY     = 2;
    localparam int ST_OVF       = 3;
    localparam int ST_COUNT_LSB = 4;

    typedef enum logic [1:0] {
        REGION_NONE = 2'd0,
        REGION_RAM  = 2'd1,
        REGION_MMIO = 2'd2
    } region_e;

    function automatic logic [31:0] pack_status(input logic [3:0] count, input logic ovf,
                                                input logic empty, input logic full,
                                                input logic match);
        return {24'b0, count, ovf, empty, full, match};
    endfunction

endpackage

// File: rtl/mips_dbus_responder_if.sv
// Bus between the single-cycle MIPS core (master) and the data-bus responder (slave).
interface mips_dbus_responder_if;
    logic        memwrite;
    logic [31:0] memaddr;
    logic [31:0] memwritedata;
    logic [31:0] memreaddata;
    // TX stream: a word transfers on every rising edge where out_valid && out_ready;
    // out_valid/out_data hold until accepted, out_ready may change freely.
    logic        out_valid;
    logic [31:0] out_data;
    logic        out_ready;
    logic        irq;

    modport master (
        output memwrite, memaddr, memwritedata, out_ready,
        input  memreaddata, out_valid, out_data, irq
    );

    modport slave (
        input  memwrite, memaddr, memwritedata, out_ready,
        output memreaddata, out_valid, out_data, irq
    );
endinterface

// File: rtl/mips_word_fifo.sv
// Synchronous word FIFO with registered pointers; a push into a full FIFO is
// accepted only when a pop frees the head slot in the same cycle.
module mips_word_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 32
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic [W-1:0]             push_data,
    input  logic                     pop,
    output logic [W-1:0]             pop_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic          push_ok, pop_ok;

    assign full     = (count_q == (AW+1)'(DEPTH));
    assign empty    = (count_q == '0);
    assign count    = count_q;
    assign pop_data = mem_q[rd_ptr_q];

    assign pop_ok  = pop & ~empty;
    assign push_ok = push & (~full | pop_ok);

    always_comb begin
        wr_ptr_d = wr_ptr_q + AW'(push_ok);
        rd_ptr_d = rd_ptr_q + AW'(pop_ok);
        count_d  = count_q + (AW+1)'(push_ok) - (AW+1)'(pop_ok);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            if (push_ok) mem_q[wr_ptr_q] <= push_data;
        end
    end

endmodule

// File: rtl/mips_dbus_responder.sv
// Data-bus target for a single-cycle MIPS core: word RAM at 0x0 plus an MMIO page
// with a cycle counter, compare/match timer and a TX FIFO; reads are combinational.
module mips_dbus_responder
    import mips_dbus_responder_pkg::*;
#(
    parameter int          RAM_WORDS  = 64,
    parameter int          FIFO_DEPTH = 4,
    parameter logic [31:0] MMIO_BASE  = 32'hFFFF0000
) (
    input  logic                   clk,
    input  logic                   reset,
    mips_dbus_responder_if.slave   bus
);
    localparam int RAM_AW = $clog2(RAM_WORDS);
    localparam int CW     = $clog2(FIFO_DEPTH) + 1;

    logic [31:0] ram_q [RAM_WORDS];
    logic [31:0] counter_q, counter_d;
    logic [31:0] compare_q, compare_d;
    logic        match_q, match_d;
    logic        ovf_q, ovf_d;

    region_e     region;
    logic [RAM_AW-1:0] ram_idx;
    logic [1:0]  mmio_off;
    logic        wr_mmio, wr_compare, wr_status, push_c, pop_c, ram_we;
    logic [31:0] rdata_c, fifo_head;
    logic        fifo_full, fifo_empty;
    logic [CW-1:0] fifo_count;

    assign ram_idx  = bus.memaddr[RAM_AW+1:2];
    assign mmio_off = bus.memaddr[3:2];

    always_comb begin
        region = REGION_NONE;
        if (bus.memaddr[31:RAM_AW+2] == '0)
            region = REGION_RAM;
        else if (bus.memaddr[31:4] == MMIO_BASE[31:4])
            region = REGION_MMIO;
    end

    assign wr_mmio    = bus.memwrite & (region == REGION_MMIO);
    assign wr_compare = wr_mmio & (mmio_off == OFF_COMPARE);
    assign wr_status  = wr_mmio & (mmio_off == OFF_STATUS);
    assign push_c     = wr_mmio & (mmio_off == OFF_TXDATA);
    assign pop_c      = ~fifo_empty & bus.out_ready;
    assign ram_we     = bus.memwrite & (region == REGION_RAM) & ~reset;

    mips_word_fifo #(
        .DEPTH (FIFO_DEPTH),
        .W     (32)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (push_c),
        .push_data (bus.memwritedata),
        .pop       (pop_c),
        .pop_data  (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    // A match uses the pre-edge counter/compare pair, and setting beats a W1C clear.
    always_comb begin
        counter_d = counter_q + 32'd1;
        compare_d = wr_compare ? bus.memwritedata : compare_q;
        match_d   = (counter_q == compare_q) |
                    (match_q & ~(wr_status & bus.memwritedata[ST_MATCH]));
        ovf_d     = (push_c & fifo_full & ~pop_c) |
                    (ovf_q & ~(wr_status & bus.memwritedata[ST_OVF]));
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            counter_q <= '0;
            compare_q <= 32'hFFFFFFFF;
            match_q   <= 1'b0;
            ovf_q     <= 1'b0;
        end else begin
            counter_q <= counter_d;
            compare_q <= compare_d;
            match_q   <= match_d;
            ovf_q     <= ovf_d;
        end
    end

    always_ff @(posedge clk) begin
        if (ram_we) ram_q[ram_idx] <= bus.memwritedata;
    end

    always_comb begin
        rdata_c = '0;
        case (region)
            REGION_RAM: rdata_c = ram_q[ram_idx];
            REGION_MMIO: begin
                case (mmio_off)
                    OFF_COUNTER: rdata_c = counter_q;
                    OFF_COMPARE: rdata_c = compare_q;
                    OFF_STATUS:  rdata_c = pack_status(4'(fifo_count), ovf_q, fifo_empty,
                                                       fifo_full, match_q);
                    default:     rdata_c = '0;
                endcase
            end
            default: rdata_c = '0;
        endcase
    end

    assign bus.memreaddata = rdata_c;
    assign bus.out_valid   = ~fifo_empty;
    assign bus.out_data    = fifo_head;
    assign bus.irq         = match_q;

endmodule
